// File: rtl/mpu_frame_averager.sv
`default_nettype none
// ============================================================================
//  Module   : mpu_frame_averager
//  Purpose  : Rebuilds MPU-6050 burst bytes into seven signed channels,
//             averages them over 2^AVG_LOG2 frames and drives a magnitude view.
//  Revision : 1.0  initial release
// ============================================================================
module mpu_frame_averager #(
    parameter int AVG_LOG2 = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        frame_start,
    input  logic        frame_abort,
    input  logic [2:0]  chan_sel,
    input  logic        clear_errors,
    output logic [15:0] avg_word,
    output logic        avg_valid,
    output logic [7:0]  display,
    output logic        frame_err,
    output logic        overrun
);

    localparam int c_ACC_W = 16 + AVG_LOG2;
    localparam int c_CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [c_CNT_W-1:0] c_WIN_LAST = c_CNT_W'((1 << AVG_LOG2) - 1);

    localparam logic [1:0] c_S_COLLECT = 2'd0;
    localparam logic [1:0] c_S_COMMIT  = 2'd1;
    localparam logic [1:0] c_S_PUBLISH = 2'd2;

    logic [1:0]                r_state;
    logic [3:0]                r_byte_idx;
    logic [7:0]                r_hi;
    logic [15:0]               r_frame_buf [7];
    logic signed [c_ACC_W-1:0] r_acc       [7];
    logic [15:0]               r_avg       [7];
    logic [c_CNT_W-1:0]        r_win_cnt;
    logic                      r_avg_valid;
    logic [7:0]                r_display;
    logic                      r_frame_err;
    logic                      r_overrun;

    logic        w_collect;
    logic        w_take;
    logic        w_accept;
    logic        w_last;
    logic [3:0]  w_idx_eff;
    logic        w_frame_evt;
    logic        w_overrun_evt;
    logic        w_win_done;
    logic [2:0]  w_sel;
    logic [15:0] w_mag;
    logic        w_unused_mag;

    // An abort in the same cycle as a byte takes priority and drops the byte.
    assign w_collect     = (r_state == c_S_COLLECT);
    assign w_take        = w_collect & byte_valid & ~frame_abort;
    assign w_accept      = w_take & (frame_start | (r_byte_idx != 4'd0));
    assign w_idx_eff     = frame_start ? 4'd0 : r_byte_idx;
    assign w_last        = w_accept & (w_idx_eff == 4'd13);
    assign w_frame_evt   = w_take & (frame_start ? (r_byte_idx != 4'd0) : (r_byte_idx == 4'd0));
    assign w_overrun_evt = byte_valid & ~w_collect;
    assign w_win_done    = (r_win_cnt == c_WIN_LAST);

    assign w_sel    = (chan_sel == 3'd7) ? 3'd0 : chan_sel;
    assign avg_word = r_avg[w_sel];

    // 0x8000 has no positive counterpart in 16 bits, so it saturates.
    always_comb begin
        w_mag = avg_word;
        if (avg_word == 16'h8000) begin
            w_mag = 16'h7FFF;
        end else if (avg_word[15]) begin
            w_mag = 16'd0 - avg_word;
        end
    end
    assign w_unused_mag = ^{w_mag[15], w_mag[6:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_S_COLLECT;
            r_byte_idx  <= 4'd0;
            r_hi        <= 8'd0;
            r_win_cnt   <= '0;
            r_avg_valid <= 1'b0;
            r_display   <= 8'd0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            for (int k = 0; k < 7; k++) begin
                r_frame_buf[k] <= 16'd0;
                r_acc[k]       <= '0;
                r_avg[k]       <= 16'd0;
            end
        end else begin
            r_avg_valid <= 1'b0;
            r_display   <= w_mag[14:7];
            r_frame_err <= w_frame_evt   | (r_frame_err & ~clear_errors);
            r_overrun   <= w_overrun_evt | (r_overrun   & ~clear_errors);

            case (r_state)
                c_S_COLLECT: begin
                    if (frame_abort) begin
                        r_byte_idx <= 4'd0;
                    end else if (w_accept) begin
                        if (!w_idx_eff[0]) begin
                            r_hi <= byte_data;
                        end else begin
                            r_frame_buf[w_idx_eff[3:1]] <= {r_hi, byte_data};
                        end
                        if (w_last) begin
                            r_byte_idx <= 4'd0;
                            r_state    <= c_S_COMMIT;
                        end else begin
                            r_byte_idx <= w_idx_eff + 4'd1;
                        end
                    end
                end
                c_S_COMMIT: begin
                    for (int k = 0; k < 7; k++) begin
                        r_acc[k] <= r_acc[k] + c_ACC_W'($signed(r_frame_buf[k]));
                    end
                    r_win_cnt <= r_win_cnt + c_CNT_W'(1);
                    if (w_win_done) begin
                        r_state     <= c_S_PUBLISH;
                        r_avg_valid <= 1'b1;
                    end else begin
                        r_state <= c_S_COLLECT;
                    end
                end
                c_S_PUBLISH: begin
                    // Arithmetic shift floors the mean toward minus infinity.
                    for (int k = 0; k < 7; k++) begin
                        r_avg[k] <= 16'(r_acc[k] >>> AVG_LOG2);
                        r_acc[k] <= '0;
                    end
                    r_win_cnt <= '0;
                    r_state   <= c_S_COLLECT;
                end
                default: begin
                    r_state <= c_S_COLLECT;
                end
            endcase
        end
    end

    assign avg_valid = r_avg_valid;
    assign display   = r_display;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_mpu_frame_averager.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mpu_frame_averager
//  Purpose  : Scoreboard bench driving three averagers (AVG_LOG2 = 0, 1, 2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mpu_frame_averager;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bv = 1'b0;
    logic [7:0]  bd = 8'd0;
    logic        fs = 1'b0;
    logic        fa = 1'b0;
    logic [2:0]  cs = 3'd0;
    logic        ce = 1'b0;

    logic [15:0] aw [3];
    logic        av [3];
    logic [7:0]  dp [3];
    logic        fe [3];
    logic        ov [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mpu_frame_averager #(.AVG_LOG2(0)) u_l0 (
        .clk(clk), .reset(reset), .byte_valid(bv), .byte_data(bd), .frame_start(fs),
        .frame_abort(fa), .chan_sel(cs), .clear_errors(ce), .avg_word(aw[0]),
        .avg_valid(av[0]), .display(dp[0]), .frame_err(fe[0]), .overrun(ov[0]));
    mpu_frame_averager #(.AVG_LOG2(1)) u_l1 (
        .clk(clk), .reset(reset), .byte_valid(bv), .byte_data(bd), .frame_start(fs),
        .frame_abort(fa), .chan_sel(cs), .clear_errors(ce), .avg_word(aw[1]),
        .avg_valid(av[1]), .display(dp[1]), .frame_err(fe[1]), .overrun(ov[1]));
    mpu_frame_averager #(.AVG_LOG2(2)) u_l2 (
        .clk(clk), .reset(reset), .byte_valid(bv), .byte_data(bd), .frame_start(fs),
        .frame_abort(fa), .chan_sel(cs), .clear_errors(ce), .avg_word(aw[2]),
        .avg_valid(av[2]), .display(dp[2]), .frame_err(fe[2]), .overrun(ov[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] disp_of(input logic [15:0] v);
        logic [15:0] m;
        if (v == 16'h8000)  m = 16'h7FFF;
        else if (v[15])     m = 16'd0 - v;
        else                m = v;
        return m[14:7];
    endfunction

    // Reference model: instance i averages over 2^i frames.
    logic [15:0]  fv   [7];
    longint       sum  [3][7];
    int           fcnt [3];
    logic [111:0] emem [3][16];
    int           wr   [3];
    int           rd   [3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 7; c++) sum[i][c] = 0;
            fcnt[i] = 0;
            rd[i]   = wr[i];
        end
    endtask

    task automatic model_frame();
        longint       a;
        logic [111:0] e;
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 7; c++) sum[i][c] += longint'($signed(fv[c]));
            fcnt[i]++;
            if (fcnt[i] == (1 << i)) begin
                for (int c = 0; c < 7; c++) begin
                    a = sum[i][c] >>> i;
                    e[c*16 +: 16] = a[15:0];
                    sum[i][c] = 0;
                end
                emem[i][wr[i] % 16] = e;
                wr[i]++;
                fcnt[i] = 0;
            end
        end
    endtask

    // Monitor: avg_valid pops an entry; avg_word is due next cycle, display one after.
    logic        pend_w [3];
    logic        pend_d [3];
    logic [15:0] exp_w  [3];
    logic [7:0]  exp_d  [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            pend_w[i] = 1'b0; pend_d[i] = 1'b0; wr[i] = 0; rd[i] = 0;
        end
        model_reset();
    end

    always @(negedge clk) begin
        logic [111:0] e;
        int           s;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                pend_w[i] = 1'b0;
                pend_d[i] = 1'b0;
            end else begin
                if (pend_d[i]) begin
                    check($sformatf("sb_display_l%0d", i), dp[i], exp_d[i]);
                    pend_d[i] = 1'b0;
                end
                if (pend_w[i]) begin
                    check($sformatf("sb_avg_word_l%0d", i), aw[i], exp_w[i]);
                    exp_d[i]  = disp_of(exp_w[i]);
                    pend_d[i] = 1'b1;
                    pend_w[i] = 1'b0;
                end
                if (av[i]) begin
                    if (rd[i] == wr[i]) begin
                        check($sformatf("sb_unexpected_valid_l%0d", i), 1, 0);
                    end else begin
                        e = emem[i][rd[i] % 16];
                        rd[i]++;
                        s = (cs == 3'd7) ? 0 : int'(cs);
                        exp_w[i]  = e[s*16 +: 16];
                        pend_w[i] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic start);
        bd = b; fs = start; bv = 1'b1;
        tick();
        bv = 1'b0; fs = 1'b0;
    endtask

    function automatic logic [7:0] byte_of(input int k);
        logic [15:0] w;
        w = fv[k / 2];
        return (k % 2 == 1) ? w[7:0] : w[15:8];
    endfunction

    task automatic send_partial(input int n);
        for (int k = 0; k < n; k++) send_byte(byte_of(k), k == 0);
    endtask

    task automatic send_frame(input logic inject);
        send_partial(14);
        model_frame();
        if (inject) begin
            bd = 8'h55; bv = 1'b1;
            tick();
            bv = 1'b0;
        end
    endtask

    task automatic wait_pub();
        repeat (4) @(negedge clk);
    endtask

    task automatic set_fv(input logic [15:0] a, input logic [15:0] t, input logic [15:0] g);
        for (int c = 0; c < 7; c++) fv[c] = 16'd0;
        fv[0] = a; fv[2] = t; fv[4] = g;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic pulse_clear();
        ce = 1'b1;
        tick();
        ce = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_avg_word_l%0d", i), aw[i], 16'h0000);
            check($sformatf("rst_display_l%0d", i), dp[i], 8'h00);
            check($sformatf("rst_flags_l%0d", i), {av[i], fe[i], ov[i]}, 3'b000);
        end

        // Single-frame publish latency and magnitude view.
        do_reset();
        cs = 3'd2;
        set_fv(16'h0000, 16'h4000, 16'h0000);
        send_frame(1'b0);
        @(negedge clk); check("lat_commit_valid", av[0], 1'b0);
        @(negedge clk); check("lat_publish_valid", av[0], 1'b1);
        @(negedge clk); check("avg_l0_4000", aw[0], 16'h4000);
        @(negedge clk); check("disp_l0_4000", dp[0], 8'h80);

        set_fv(16'h0000, 16'hC000, 16'h0000);
        send_frame(1'b0); wait_pub();
        check("avg_l0_c000", aw[0], 16'hC000);
        check("disp_l0_c000", dp[0], 8'h80);
        check("avg_l1_cancel", aw[1], 16'h0000);
        set_fv(16'h0000, 16'h8000, 16'h0000);
        send_frame(1'b0); wait_pub();
        check("avg_l0_8000", aw[0], 16'h8000);
        check("disp_l0_sat", dp[0], 8'hFF);

        // Four-frame windows on gyrox.
        do_reset();
        cs = 3'd4;
        set_fv(16'h0123, 16'h0000, 16'd100); send_frame(1'b0); wait_pub();
        set_fv(16'h0123, 16'h0000, 16'd200); send_frame(1'b0); wait_pub();
        set_fv(16'h0123, 16'h0000, 16'd300); send_frame(1'b0); wait_pub();
        set_fv(16'h0123, 16'h0000, 16'd400); send_frame(1'b0); wait_pub();
        check("avg_l2_win1", aw[2], 16'h00FA);
        check("disp_l2_win1", dp[2], 8'h01);
        check("avg_l1_win2", aw[1], 16'h015E);
        set_fv(16'h0123, 16'h0000, 16'hFFFF); send_frame(1'b0); wait_pub();
        set_fv(16'h0123, 16'h0000, 16'hFFFE); send_frame(1'b0); wait_pub();
        set_fv(16'h0123, 16'h0000, 16'hFFFE); send_frame(1'b0); wait_pub();
        set_fv(16'h0123, 16'h0000, 16'hFFFE); send_frame(1'b0); wait_pub();
        check("avg_l2_win2_floor", aw[2], 16'hFFFE);
        check("avg_l1_neg", aw[1], 16'hFFFE);
        cs = 3'd7;
        #1 check("chan7_is_acclx", aw[2], 16'h0123);
        cs = 3'd3;
        #1 check("chan3_temp", aw[2], 16'h0000);
        cs = 3'd7;
        tick();
        @(negedge clk); check("disp_follows_sel", dp[2], 8'h02);

        // Framing violations and sticky flags.
        cs = 3'd2;
        pulse_clear();
        send_byte(8'hAA, 1'b0);
        @(negedge clk); check("orphan_byte_err", fe[0], 1'b1);
        pulse_clear();
        @(negedge clk); check("clear_err", fe[2], 1'b0);
        set_fv(16'h0000, 16'h2000, 16'h0000);
        send_partial(6);
        @(negedge clk); check("partial_no_err", fe[1], 1'b0);
        send_frame(1'b0); wait_pub();
        check("restart_err", fe[0], 1'b1);
        check("restart_frame_ok", aw[0], 16'h2000);
        pulse_clear();
        @(negedge clk); check("restart_err_clr", fe[0], 1'b0);

        // Abort, overrun in COMMIT, and set-over-clear priority.
        set_fv(16'h7777, 16'h1111, 16'h0000);
        send_partial(10);
        bd = 8'h99; bv = 1'b1; fa = 1'b1;
        tick();
        bv = 1'b0; fa = 1'b0;
        set_fv(16'h0000, 16'h0800, 16'h0000);
        send_frame(1'b1); wait_pub();
        check("abort_no_err", fe[0], 1'b0);
        check("overrun_set_l0", ov[0], 1'b1);
        check("overrun_set_l2", ov[2], 1'b1);
        check("abort_frame_ok", aw[0], 16'h0800);
        set_fv(16'h0000, 16'h0400, 16'h0000);
        send_frame(1'b0); wait_pub();
        check("after_overrun_ok", aw[0], 16'h0400);
        ce = 1'b1;
        send_byte(8'h12, 1'b0);
        ce = 1'b0;
        @(negedge clk);
        check("set_beats_clear", fe[1], 1'b1);
        check("overrun_cleared", ov[1], 1'b0);
        pulse_clear();

        // Reset mid-window.
        do_reset();
        set_fv(16'h0000, 16'h3000, 16'h0000);
        send_frame(1'b1); wait_pub();
        check("pre_reset_avg", aw[0], 16'h3000);
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("async_rst_avg_l%0d", i), aw[i], 16'h0000);
            check($sformatf("async_rst_rest_l%0d", i), {av[i], dp[i], fe[i], ov[i]}, 11'h000);
        end
        tick();
        reset = 1'b0;
        model_reset();
        set_fv(16'h0000, 16'h0200, 16'h0000);
        send_frame(1'b0); wait_pub();
        check("l1_needs_two", aw[1], 16'h0000);
        set_fv(16'h0000, 16'h0400, 16'h0000);
        send_frame(1'b0); wait_pub();
        check("l1_after_two", aw[1], 16'h0300);

        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) check($sformatf("sb_drained_l%0d", i), rd[i], wr[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mpu_frame_averager.md
Name: mpu_frame_averager

Overview:
- Downstream consumer of the MPU-6050 burst read: takes the 14 register bytes (0x3B..0x48) as the sensor-read sequencer receives them from i2c_controller.
- Reassembles the bytes into seven signed 16-bit channels: acclx, accly, acclz, temp, gyrox, gyroy, gyroz.
- Averages each channel over a power-of-two window of frames and drives the 8-bit board display with a magnitude view of one selectable channel.

Parameters:
- AVG_LOG2, 3, log2 of frames per averaging window. Legal range 0..4; 0 means every frame is published unaveraged.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- byte_valid  input  1  one-cycle strobe: byte_data holds one received sensor byte
- byte_data  input  8  received byte, big-endian per channel (high byte first)
- frame_start  input  1  asserted together with byte_valid on byte 0 (register 0x3B) of a burst
- frame_abort  input  1  one-cycle pulse on NACK/HALT; discards the partial frame
- chan_sel  input  3  display/readout channel, 0=acclx .. 6=gyroz; 7 is treated as 0
- clear_errors  input  1  clears the sticky flags
- avg_word  output  16  averaged value of the selected channel (combinational from avg regs)
- avg_valid  output  1  one-cycle pulse when new averages are published
- display  output  8  registered magnitude view of the selected channel
- frame_err  output  1  sticky: framing violation seen
- overrun  output  1  sticky: byte arrived while not collecting

Behaviour:
- Reset (async): state=COLLECT, byte_idx=0, hi_reg=0, all frame_buf/acc/avg regs=0, win_cnt=0, avg_valid=0, display=0, frame_err=0, overrun=0.
- States: COLLECT -> COMMIT -> (PUBLISH | COLLECT); PUBLISH -> COLLECT. COMMIT and PUBLISH each last exactly 1 cycle.
- COLLECT, byte_valid with frame_start: byte taken as byte 0 and byte_idx=1.
  - If byte_idx was not 0, the partial frame is dropped and frame_err is set.
- COLLECT, byte_valid without frame_start:
  - byte_idx==0: byte ignored, frame_err set.
  - Otherwise the byte is accepted.
- Byte storage:
  - Even byte_idx: byte goes to hi_reg.
  - Odd byte_idx: frame_buf[byte_idx>>1] <= {hi_reg, byte_data}.
  - byte_idx increments after each accepted byte.
- Frame completion: accepting byte 13 sets byte_idx=0 and moves to COMMIT on the next edge.
- frame_abort in COLLECT: byte_idx=0, partial frame discarded, no flag.
  - frame_abort and byte_valid in the same cycle: the abort wins and the byte is ignored.
- COMMIT:
  - acc[k] <= acc[k] + sign-extended frame_buf[k] for all 7 channels in parallel. Accumulators are 16+AVG_LOG2 bits, so they cannot overflow.
  - win_cnt increments.
  - If win_cnt was 2^AVG_LOG2-1: go to PUBLISH, else COLLECT.
- PUBLISH:
  - avg[k] <= acc[k] >>> AVG_LOG2 (arithmetic shift, rounds toward −inf).
  - acc[k] cleared, win_cnt=0, avg_valid=1 for this cycle only.
- byte_valid during COMMIT/PUBLISH: byte ignored, overrun set, byte_idx unchanged. frame_abort in these states has no effect.
- avg_word = avg[chan_sel]. It changes the cycle after PUBLISH, or immediately when chan_sel changes.
- display is registered every cycle, 1-cycle latency from avg/chan_sel:
  - mag = |avg_word|, saturated to 0x7FFF when avg_word==0x8000.
  - display = mag[14:7].
- Sticky flags: clear_errors clears frame_err and overrun. If an error event occurs in the same cycle as clear_errors, the set wins.
- Reset mid-frame or mid-window discards everything. The first publish after reset needs a full 2^AVG_LOG2 frames.

Test Plan:
- AVG_LOG2=0, one frame with acclz bytes 0x40,0x00 (others 0), chan_sel=2 -> avg_valid pulses 2 cycles after byte 13, avg_word=0x4000, display=0x80 one cycle later.
- AVG_LOG2=0, acclz=0xC000 -> display=0x80. acclz=0x8000 -> avg_word=0x8000, display=0xFF (saturation).
- AVG_LOG2=2, four frames with gyrox=100,200,300,400, chan_sel=4 -> exactly one avg_valid, after the 4th frame, avg_word=0x00FA. Next, four frames of −1,−2,−2,−2 -> avg_word=0xFFFE.
- Restart framing: 6 bytes sent, then frame_start with a new byte -> frame_err=1, the new 14-byte frame is accepted correctly. Then clear_errors -> frame_err=0.
- frame_abort after byte 9, then a full frame -> no frame_err, averages reflect only the full frame. A byte_valid injected in the COMMIT cycle -> overrun=1, the next frame is still accepted.
- Reset asserted mid-window (AVG_LOG2=1, after 1 frame) -> all outputs 0 immediately. Two new frames are then required before avg_valid.
